// File: rtl/zap_wb_burst_arbiter.sv
// Two-master (code/data) to one-slave Wishbone arbiter. Grant is held for a whole
// classic cycle or CTI incrementing burst, with a one-cycle idle gap between grants.
module zap_wb_burst_arbiter #(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned WDT_CYCLES  = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,

  input  logic        i_c_wb_cyc,
  input  logic        i_c_wb_stb,
  input  logic        i_c_wb_we,
  input  logic [3:0]  i_c_wb_sel,
  input  logic [2:0]  i_c_wb_cti,
  input  logic [31:0] i_c_wb_adr,
  input  logic [31:0] i_c_wb_dat,
  output logic        o_c_wb_ack,
  output logic [31:0] o_c_wb_dat,

  input  logic        i_d_wb_cyc,
  input  logic        i_d_wb_stb,
  input  logic        i_d_wb_we,
  input  logic [3:0]  i_d_wb_sel,
  input  logic [2:0]  i_d_wb_cti,
  input  logic [31:0] i_d_wb_adr,
  input  logic [31:0] i_d_wb_dat,
  output logic        o_d_wb_ack,
  output logic [31:0] o_d_wb_dat,

  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [2:0]  o_wb_cti,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat,
  output logic        o_wb_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_C = 2'd1, GNT_D = 2'd2} state_t;

  localparam logic [31:0] WDT_LIMIT = 32'(WDT_CYCLES);
  localparam bit          WDT_EN    = (WDT_CYCLES != 0);

  state_t      state_ff;
  logic        last_ff;
  logic [31:0] wdt_ff;

  logic req_c, req_d, gnt_c, gnt_d;
  logic m_cyc, m_stb, ack_eff, wdt_fire, rel_now;

  assign req_c = i_c_wb_cyc & i_c_wb_stb;
  assign req_d = i_d_wb_cyc & i_d_wb_stb;
  assign gnt_c = (state_ff == GNT_C);
  assign gnt_d = (state_ff == GNT_D);

  assign m_cyc = (gnt_c & i_c_wb_cyc) | (gnt_d & i_d_wb_cyc);
  assign m_stb = (gnt_c & i_c_wb_stb) | (gnt_d & i_d_wb_stb);

  // A slave ack while the granted master has stb low is ignored entirely.
  assign ack_eff  = m_stb & i_wb_ack;
  assign wdt_fire = WDT_EN && (gnt_c || gnt_d) && (wdt_ff == WDT_LIMIT) && !ack_eff;
  assign rel_now  = (ack_eff && (o_wb_cti != 3'b010)) || !m_cyc || wdt_fire;
  assign o_wb_err = wdt_fire;

  always_comb begin
    o_wb_cyc   = 1'b0;
    o_wb_stb   = 1'b0;
    o_wb_we    = 1'b0;
    o_wb_sel   = '0;
    o_wb_cti   = '0;
    o_wb_adr   = '0;
    o_wb_dat   = '0;
    o_c_wb_ack = 1'b0;
    o_c_wb_dat = '0;
    o_d_wb_ack = 1'b0;
    o_d_wb_dat = '0;
    if (gnt_c) begin
      o_wb_cyc   = i_c_wb_cyc;
      o_wb_stb   = i_c_wb_stb;
      o_wb_we    = i_c_wb_we;
      o_wb_sel   = i_c_wb_sel;
      o_wb_cti   = i_c_wb_cti;
      o_wb_adr   = i_c_wb_adr;
      o_wb_dat   = i_c_wb_dat;
      o_c_wb_ack = ack_eff;
      o_c_wb_dat = i_wb_dat;
    end else if (gnt_d) begin
      o_wb_cyc   = i_d_wb_cyc;
      o_wb_stb   = i_d_wb_stb;
      o_wb_we    = i_d_wb_we;
      o_wb_sel   = i_d_wb_sel;
      o_wb_cti   = i_d_wb_cti;
      o_wb_adr   = i_d_wb_adr;
      o_wb_dat   = i_d_wb_dat;
      o_d_wb_ack = ack_eff;
      o_d_wb_dat = i_wb_dat;
    end
  end

  // last_ff = 1 means data was granted last, so code wins the first tie after reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_ff <= IDLE;
      last_ff  <= 1'b1;
      wdt_ff   <= '0;
    end else begin
      case (state_ff)
        IDLE: begin
          wdt_ff <= '0;
          if (req_c && req_d) begin
            if (ROUND_ROBIN && last_ff) begin
              state_ff <= GNT_C;
              last_ff  <= 1'b0;
            end else begin
              state_ff <= GNT_D;
              last_ff  <= 1'b1;
            end
          end else if (req_c) begin
            state_ff <= GNT_C;
            last_ff  <= 1'b0;
          end else if (req_d) begin
            state_ff <= GNT_D;
            last_ff  <= 1'b1;
          end
        end
        GNT_C, GNT_D: begin
          if (rel_now) begin
            state_ff <= IDLE;
            wdt_ff   <= '0;
          end else if (ack_eff || !m_stb || !WDT_EN) begin
            wdt_ff <= '0;
          end else begin
            wdt_ff <= wdt_ff + 32'd1;
          end
        end
        default: state_ff <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zap_wb_burst_arbiter.sv
// Scoreboard bench: instance a (round robin, watchdog 8) and instance b (fixed priority,
// watchdog off) share all inputs; acked beats of instance a are checked against a queue.
module tb_zap_wb_burst_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_c_wb_cyc, i_c_wb_stb, i_c_wb_we;
  logic [3:0]  i_c_wb_sel;
  logic [2:0]  i_c_wb_cti;
  logic [31:0] i_c_wb_adr, i_c_wb_dat;
  logic        i_d_wb_cyc, i_d_wb_stb, i_d_wb_we;
  logic [3:0]  i_d_wb_sel;
  logic [2:0]  i_d_wb_cti;
  logic [31:0] i_d_wb_adr, i_d_wb_dat;
  logic        i_wb_ack;
  logic [31:0] i_wb_dat;

  logic        o_c_wb_ack_a, o_d_wb_ack_a, o_wb_cyc_a, o_wb_stb_a, o_wb_we_a, o_wb_err_a;
  logic [31:0] o_c_wb_dat_a, o_d_wb_dat_a, o_wb_adr_a, o_wb_dat_a;
  logic [3:0]  o_wb_sel_a;
  logic [2:0]  o_wb_cti_a;
  logic        o_c_wb_ack_b, o_d_wb_ack_b, o_wb_cyc_b, o_wb_stb_b, o_wb_we_b, o_wb_err_b;
  logic [31:0] o_c_wb_dat_b, o_d_wb_dat_b, o_wb_adr_b, o_wb_dat_b;
  logic [3:0]  o_wb_sel_b;
  logic [2:0]  o_wb_cti_b;

  typedef struct {
    logic        isData;
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  beat_t sbQueue[$];
  int    assertCount = 0;
  int    failCount   = 0;

  always #5 i_clk = ~i_clk;

  zap_wb_burst_arbiter #(.ROUND_ROBIN(1'b1), .WDT_CYCLES(8)) dutA (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_c_wb_cyc(i_c_wb_cyc), .i_c_wb_stb(i_c_wb_stb), .i_c_wb_we(i_c_wb_we),
    .i_c_wb_sel(i_c_wb_sel), .i_c_wb_cti(i_c_wb_cti), .i_c_wb_adr(i_c_wb_adr),
    .i_c_wb_dat(i_c_wb_dat), .o_c_wb_ack(o_c_wb_ack_a), .o_c_wb_dat(o_c_wb_dat_a),
    .i_d_wb_cyc(i_d_wb_cyc), .i_d_wb_stb(i_d_wb_stb), .i_d_wb_we(i_d_wb_we),
    .i_d_wb_sel(i_d_wb_sel), .i_d_wb_cti(i_d_wb_cti), .i_d_wb_adr(i_d_wb_adr),
    .i_d_wb_dat(i_d_wb_dat), .o_d_wb_ack(o_d_wb_ack_a), .o_d_wb_dat(o_d_wb_dat_a),
    .o_wb_cyc(o_wb_cyc_a), .o_wb_stb(o_wb_stb_a), .o_wb_we(o_wb_we_a),
    .o_wb_sel(o_wb_sel_a), .o_wb_cti(o_wb_cti_a), .o_wb_adr(o_wb_adr_a),
    .o_wb_dat(o_wb_dat_a), .i_wb_ack(i_wb_ack), .i_wb_dat(i_wb_dat),
    .o_wb_err(o_wb_err_a)
  );

  zap_wb_burst_arbiter #(.ROUND_ROBIN(1'b0), .WDT_CYCLES(0)) dutB (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_c_wb_cyc(i_c_wb_cyc), .i_c_wb_stb(i_c_wb_stb), .i_c_wb_we(i_c_wb_we),
    .i_c_wb_sel(i_c_wb_sel), .i_c_wb_cti(i_c_wb_cti), .i_c_wb_adr(i_c_wb_adr),
    .i_c_wb_dat(i_c_wb_dat), .o_c_wb_ack(o_c_wb_ack_b), .o_c_wb_dat(o_c_wb_dat_b),
    .i_d_wb_cyc(i_d_wb_cyc), .i_d_wb_stb(i_d_wb_stb), .i_d_wb_we(i_d_wb_we),
    .i_d_wb_sel(i_d_wb_sel), .i_d_wb_cti(i_d_wb_cti), .i_d_wb_adr(i_d_wb_adr),
    .i_d_wb_dat(i_d_wb_dat), .o_d_wb_ack(o_d_wb_ack_b), .o_d_wb_dat(o_d_wb_dat_b),
    .o_wb_cyc(o_wb_cyc_b), .o_wb_stb(o_wb_stb_b), .o_wb_we(o_wb_we_b),
    .o_wb_sel(o_wb_sel_b), .o_wb_cti(o_wb_cti_b), .o_wb_adr(o_wb_adr_b),
    .o_wb_dat(o_wb_dat_b), .i_wb_ack(i_wb_ack), .i_wb_dat(i_wb_dat),
    .o_wb_err(o_wb_err_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit isData, input logic cyc, input logic stb,
                               input logic we, input logic [2:0] cti,
                               input logic [31:0] adr, input logic [31:0] dat);
    if (isData) begin
      i_d_wb_cyc = cyc; i_d_wb_stb = stb; i_d_wb_we = we; i_d_wb_sel = 4'hF;
      i_d_wb_cti = cti; i_d_wb_adr = adr; i_d_wb_dat = dat;
    end else begin
      i_c_wb_cyc = cyc; i_c_wb_stb = stb; i_c_wb_we = we; i_c_wb_sel = 4'hF;
      i_c_wb_cti = cti; i_c_wb_adr = adr; i_c_wb_dat = dat;
    end
  endtask

  task automatic setSlave(input logic ack, input logic [31:0] dat);
    i_wb_ack = ack;
    i_wb_dat = dat;
  endtask

  // The bench plays the slave: an ack it intends to be forwarded is recorded here.
  task automatic ackBeat(input bit isData, input logic [31:0] adr, input logic [31:0] dat);
    beat_t b;
    b.isData = isData; b.adr = adr; b.dat = dat;
    sbQueue.push_back(b);
    setSlave(1'b1, dat);
  endtask

  task automatic nextCycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic doReset();
    nextCycle();
    i_reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    applyStimulus(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    setSlave(1'b0, 32'h0);
    nextCycle();
    nextCycle();
    i_reset = 1'b0;
  endtask

  always @(negedge i_clk) begin
    if (o_wb_cyc_a && o_wb_stb_a && i_wb_ack) begin
      if (sbQueue.size() == 0) begin
        checkOutput("sb_expected_beat", 32'(sbQueue.size()), 32'd1);
      end else begin
        beat_t b;
        b = sbQueue.pop_front();
        checkOutput("sb_adr", o_wb_adr_a, b.adr);
        checkOutput("sb_c_ack", {31'd0, o_c_wb_ack_a}, {31'd0, !b.isData});
        checkOutput("sb_d_ack", {31'd0, o_d_wb_ack_a}, {31'd0, b.isData});
        checkOutput("sb_rdat", b.isData ? o_d_wb_dat_a : o_c_wb_dat_a, b.dat);
        checkOutput("sb_other_dat", b.isData ? o_c_wb_dat_a : o_d_wb_dat_a, 32'h0);
      end
    end
  end

  initial begin
    // Reset values with a live request and ack on the inputs.
    i_reset = 1'b1;
    applyStimulus(0, 1, 1, 0, 3'b111, 32'h100, 32'h0);
    applyStimulus(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    setSlave(1'b1, 32'hFFFF_FFFF);
    nextCycle();
    @(negedge i_clk);
    checkOutput("rst_cyc", {31'd0, o_wb_cyc_a}, 32'd0);
    checkOutput("rst_adr", o_wb_adr_a, 32'd0);
    checkOutput("rst_c_ack", {31'd0, o_c_wb_ack_a}, 32'd0);
    checkOutput("rst_c_dat", o_c_wb_dat_a, 32'd0);
    checkOutput("rst_err", {31'd0, o_wb_err_a}, 32'd0);

    // Code single read.
    doReset();
    nextCycle();
    applyStimulus(0, 1, 1, 0, 3'b111, 32'h100, 32'h0);
    @(negedge i_clk);
    checkOutput("t1_idle_stb", {31'd0, o_wb_stb_a}, 32'd0);
    nextCycle();
    @(negedge i_clk);
    checkOutput("t1_stb", {31'd0, o_wb_stb_a}, 32'd1);
    checkOutput("t1_adr", o_wb_adr_a, 32'h100);
    checkOutput("t1_cti", {29'd0, o_wb_cti_a}, 32'd7);
    nextCycle();
    @(negedge i_clk);
    checkOutput("t1_no_ack", {31'd0, o_c_wb_ack_a}, 32'd0);
    nextCycle();
    ackBeat(0, 32'h100, 32'hDEAD_BEEF);
    nextCycle();
    setSlave(1'b0, 32'h0);
    applyStimulus(0, 1, 0, 0, 3'b111, 32'h100, 32'h0);
    @(negedge i_clk);
    checkOutput("t1_release_cyc", {31'd0, o_wb_cyc_a}, 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0);

    // Data 4-beat burst; code requests mid-burst and must wait.
    doReset();
    nextCycle();
    applyStimulus(1, 1, 1, 0, 3'b010, 32'h200, 32'h0);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      applyStimulus(1, 1, 1, 0, (i < 3) ? 3'b010 : 3'b111, 32'h200 + 32'(4 * i), 32'h0);
      if (i == 1) applyStimulus(0, 1, 1, 0, 3'b111, 32'h300, 32'h0);
      ackBeat(1, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
    end
    nextCycle();
    setSlave(1'b0, 32'h0);
    applyStimulus(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge i_clk);
    checkOutput("t2_idle_gap", {31'd0, o_wb_cyc_a}, 32'd0);
    nextCycle();
    @(negedge i_clk);
    checkOutput("t2_code_cyc", {31'd0, o_wb_cyc_a}, 32'd1);
    nextCycle();
    ackBeat(0, 32'h300, 32'h3333_0000);
    nextCycle();
    setSlave(1'b0, 32'h0);
    applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0);

    // Tie: instance a alternates C,D,C,D; instance b always grants data.
    doReset();
    nextCycle();
    applyStimulus(0, 1, 1, 0, 3'b111, 32'h400, 32'h0);
    applyStimulus(1, 1, 1, 0, 3'b111, 32'h500, 32'h0);
    setSlave(1'b1, 32'hC0DE_0000);
    @(negedge i_clk);
    checkOutput("t3_cyc_0", {31'd0, o_wb_cyc_a}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      nextCycle();
      if (k % 2 == 1) begin
        ackBeat(((k >> 1) & 1) == 1, ((k >> 1) & 1) == 1 ? 32'h500 : 32'h400,
                32'hC0DE_0000 + 32'(k));
      end else begin
        setSlave(1'b1, 32'hC0DE_0000 + 32'(k));
      end
      @(negedge i_clk);
      checkOutput("t3_rr_cyc", {31'd0, o_wb_cyc_a}, 32'(k % 2));
      checkOutput("t3_fixed_cyc", {31'd0, o_wb_cyc_b}, 32'(k % 2));
      if (k % 2 == 1) begin
        checkOutput("t3_fixed_d_ack", {31'd0, o_d_wb_ack_b}, 32'd1);
        checkOutput("t3_fixed_c_ack", {31'd0, o_c_wb_ack_b}, 32'd0);
      end
    end
    nextCycle();
    setSlave(1'b0, 32'h0);
    applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    applyStimulus(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);

    // Stb gap in a data write stream with a stray ack inside the gap.
    doReset();
    nextCycle();
    applyStimulus(1, 1, 1, 1, 3'b010, 32'h600, 32'h11);
    nextCycle();
    ackBeat(1, 32'h600, 32'h6000);
    @(negedge i_clk);
    checkOutput("t4_we", {31'd0, o_wb_we_a}, 32'd1);
    checkOutput("t4_wdat", o_wb_dat_a, 32'h11);
    for (int g = 0; g < 3; g++) begin
      nextCycle();
      applyStimulus(1, 1, 0, 1, 3'b010, 32'h604, 32'h22);
      setSlave(g == 1, 32'h6666);
      @(negedge i_clk);
      checkOutput("t4_gap_cyc", {31'd0, o_wb_cyc_a}, 32'd1);
      checkOutput("t4_gap_stb", {31'd0, o_wb_stb_a}, 32'd0);
      checkOutput("t4_gap_ack", {31'd0, o_d_wb_ack_a}, 32'd0);
    end
    nextCycle();
    applyStimulus(1, 1, 1, 1, 3'b111, 32'h604, 32'h22);
    ackBeat(1, 32'h604, 32'h6004);
    @(negedge i_clk);
    checkOutput("t4_resume_cyc", {31'd0, o_wb_cyc_a}, 32'd1);
    nextCycle();
    setSlave(1'b0, 32'h0);
    applyStimulus(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);

    // Watchdog: slave never acks; fires 8 cycles after stb rises.
    doReset();
    nextCycle();
    applyStimulus(1, 1, 1, 0, 3'b111, 32'h700, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      nextCycle();
      @(negedge i_clk);
      checkOutput("t5_err", {31'd0, o_wb_err_a}, (c == 9) ? 32'd1 : 32'd0);
      checkOutput("t5_cyc", {31'd0, o_wb_cyc_a}, (c == 10) ? 32'd0 : 32'd1);
      checkOutput("t5_no_ack", {31'd0, o_d_wb_ack_a}, 32'd0);
      checkOutput("t5_wdt_off_err", {31'd0, o_wb_err_b}, 32'd0);
      checkOutput("t5_wdt_off_cyc", {31'd0, o_wb_cyc_b}, 32'd1);
    end
    nextCycle();
    applyStimulus(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);

    // Ack arriving exactly when the watchdog reaches its limit wins.
    doReset();
    nextCycle();
    applyStimulus(1, 1, 1, 0, 3'b010, 32'h780, 32'h0);
    repeat (8) nextCycle();
    nextCycle();
    ackBeat(1, 32'h780, 32'h78);
    @(negedge i_clk);
    checkOutput("t5b_err", {31'd0, o_wb_err_a}, 32'd0);
    nextCycle();
    setSlave(1'b0, 32'h0);
    @(negedge i_clk);
    checkOutput("t5b_cyc", {31'd0, o_wb_cyc_a}, 32'd1);
    checkOutput("t5b_err_after", {31'd0, o_wb_err_a}, 32'd0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);

    // Reset mid-burst on beat 2 of a code burst, then a tie must grant code.
    doReset();
    nextCycle();
    applyStimulus(0, 1, 1, 0, 3'b010, 32'h800, 32'h0);
    nextCycle();
    ackBeat(0, 32'h800, 32'h81);
    nextCycle();
    applyStimulus(0, 1, 1, 0, 3'b010, 32'h804, 32'h0);
    ackBeat(0, 32'h804, 32'h82);
    nextCycle();
    applyStimulus(0, 1, 1, 0, 3'b010, 32'h808, 32'h0);
    setSlave(1'b0, 32'h0);
    i_reset = 1'b1;
    nextCycle();
    setSlave(1'b1, 32'h5A5A_5A5A);
    @(negedge i_clk);
    checkOutput("t6_cyc", {31'd0, o_wb_cyc_a}, 32'd0);
    checkOutput("t6_stb", {31'd0, o_wb_stb_a}, 32'd0);
    checkOutput("t6_adr", o_wb_adr_a, 32'd0);
    checkOutput("t6_cti", {29'd0, o_wb_cti_a}, 32'd0);
    checkOutput("t6_c_ack", {31'd0, o_c_wb_ack_a}, 32'd0);
    checkOutput("t6_c_dat", o_c_wb_dat_a, 32'd0);
    nextCycle();
    i_reset = 1'b0;
    setSlave(1'b0, 32'h0);
    applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    nextCycle();
    applyStimulus(0, 1, 1, 0, 3'b111, 32'h900, 32'h0);
    applyStimulus(1, 1, 1, 0, 3'b111, 32'hA00, 32'h0);
    @(negedge i_clk);
    checkOutput("t6_tie_idle", {31'd0, o_wb_cyc_a}, 32'd0);
    nextCycle();
    ackBeat(0, 32'h900, 32'h99);
    @(negedge i_clk);
    checkOutput("t6_tie_code", o_wb_adr_a, 32'h900);
    nextCycle();
    setSlave(1'b0, 32'h0);
    applyStimulus(0, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    applyStimulus(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);
    nextCycle();
    nextCycle();

    checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
